// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller.
//   Combinational per-stage stall vector (mem > ex > load priority), and a
//   RUN/PEND/FLUSH redirect FSM that turns an exception pulse into a
//   registered one-cycle flush carrying the captured target PC.
//   Adds a sticky consecutive-stall watchdog and a saturating stall counter.
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   stallreq_for_load/ex/mem : hazard requests from ID / EX / MEM
//   except_valid, except_pc  : redirect request pulse and target
//   stall [STALL_W]       : hold vector, bit 0 = PC, bit i = stage i
//   flush, new_pc         : one-cycle registered flush and its target
//   stall_timeout         : sticky watchdog error
//   stall_cycles [CNT_W]  : saturating count of cycles with stall[0]=1
module pipe_ctrl #(
  parameter int STALL_W   = 6,
  parameter int ID_IDX    = 2,
  parameter int EX_IDX    = 3,
  parameter int MEM_IDX   = 4,
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_for_load,
  input  logic               stallreq_for_ex,
  input  logic               stallreq_for_mem,
  input  logic               except_valid,
  input  logic [31:0]        except_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               stall_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  // Contiguous masks covering bits [idx:0].
  localparam logic [STALL_W-1:0] ALL_ONES = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] MEM_MASK = ALL_ONES >> (STALL_W - 1 - MEM_IDX);
  localparam logic [STALL_W-1:0] EX_MASK  = ALL_ONES >> (STALL_W - 1 - EX_IDX);
  localparam logic [STALL_W-1:0] ID_MASK  = ALL_ONES >> (STALL_W - 1 - ID_IDX);

  // Watchdog counter only needs to reach MAX_STALL, where it saturates.
  localparam int               RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] MAX_V = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             cap_en;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // Next state, capture enable and stall vector.
  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    stall      = '0;

    // The flush cycle itself never holds: the wrong-path instructions are
    // being discarded and the PC is being redirected.
    if (!rst && state != FLUSH) begin
      if      (stallreq_for_mem)  stall = MEM_MASK;
      else if (stallreq_for_ex)   stall = EX_MASK;
      else if (stallreq_for_load) stall = ID_MASK;
    end

    case (state)
      RUN: begin
        if (except_valid) begin
          cap_en     = 1'b1;
          // A stalled MEM stage cannot be flushed mid-access; wait it out.
          next_state = stallreq_for_mem ? PEND : FLUSH;
        end
      end
      PEND: begin
        // Later exceptions are ignored: the first one wins.
        if (!stallreq_for_mem) next_state = FLUSH;
      end
      FLUSH:   next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  assign flush = (state == FLUSH);

  always_comb begin
    run_cnt_nxt = '0;
    if (stall != '0) begin
      run_cnt_nxt = (run_cnt == MAX_V) ? run_cnt : run_cnt + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_pc        <= '0;
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      if (cap_en) new_pc <= except_pc;
      run_cnt <= run_cnt_nxt;
      if (run_cnt_nxt == MAX_V) stall_timeout <= 1'b1;
      if (stall[0] && stall_cycles != {CNT_W{1'b1}}) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MAX_STALL=4 and CNT_W=3 so that the
// watchdog and counter saturation are reachable in a few cycles.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_for_load;
  logic        stallreq_for_ex;
  logic        stallreq_for_mem;
  logic        except_valid;
  logic [31:0] except_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [2:0]  stall_cycles;

  int compared = 0;
  int mismatched = 0;

  pipe_ctrl #(
    .STALL_W  (6),
    .ID_IDX   (2),
    .EX_IDX   (3),
    .MEM_IDX  (4),
    .MAX_STALL(4),
    .CNT_W    (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_for_load(stallreq_for_load),
    .stallreq_for_ex  (stallreq_for_ex),
    .stallreq_for_mem (stallreq_for_mem),
    .except_valid     (except_valid),
    .except_pc        (except_pc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic clear_inputs();
    stallreq_for_load = 1'b0;
    stallreq_for_ex   = 1'b0;
    stallreq_for_mem  = 1'b0;
    except_valid      = 1'b0;
    except_pc         = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();

    // Reset: stall forced low while rst=1 even with every request high.
    rst = 1'b1;
    stallreq_for_load = 1'b1;
    stallreq_for_ex   = 1'b1;
    stallreq_for_mem  = 1'b1;
    tick();
    tick();
    check("rst_stall", stall, 6'b000000);
    check("rst_flush", flush, 0);
    check("rst_new_pc", new_pc, 0);
    check("rst_timeout", stall_timeout, 0);
    check("rst_cycles", stall_cycles, 0);
    rst = 1'b0;
    clear_inputs();
    #1;

    // Stall encoding and priority (no clock edges in between).
    stallreq_for_load = 1'b1; #1;
    check("enc_load", stall, 6'b000111);
    stallreq_for_ex = 1'b1; #1;
    check("enc_load_ex", stall, 6'b001111);
    stallreq_for_mem = 1'b1; #1;
    check("enc_all", stall, 6'b011111);
    stallreq_for_load = 1'b0; stallreq_for_mem = 1'b0; #1;
    check("enc_ex", stall, 6'b001111);
    stallreq_for_ex = 1'b0; #1;
    check("enc_none", stall, 6'b000000);

    // Exception with MEM idle: flush one cycle later, stall suppressed.
    do_reset();
    except_valid = 1'b1;
    except_pc    = 32'hBFC0_0380;
    tick();
    except_valid    = 1'b0;
    stallreq_for_ex = 1'b1;
    #1;
    check("exc_flush", flush, 1);
    check("exc_new_pc", new_pc, 32'hBFC0_0380);
    check("exc_stall_in_flush", stall, 6'b000000);
    tick();
    check("exc_flush_drop", flush, 0);
    check("exc_pc_hold", new_pc, 32'hBFC0_0380);
    check("exc_stall_after", stall, 6'b001111);
    stallreq_for_ex = 1'b0;

    // Exception during a MEM wait: deferred, first PC wins, single flush.
    do_reset();
    stallreq_for_mem = 1'b1;
    except_valid     = 1'b1;
    except_pc        = 32'hA000_0000;
    tick();
    except_pc = 32'h0000_1234;
    #1;
    check("pend_flush1", flush, 0);
    check("pend_stall", stall, 6'b011111);
    tick();
    except_valid = 1'b0;
    except_pc    = 32'h0;
    #1;
    check("pend_flush2", flush, 0);
    tick();
    check("pend_flush3", flush, 0);
    stallreq_for_mem = 1'b0;
    tick();
    check("pend_flush_go", flush, 1);
    check("pend_new_pc", new_pc, 32'hA000_0000);
    tick();
    check("pend_flush_once", flush, 0);
    tick();
    check("pend_flush_none", flush, 0);
    check("pend_cycles", stall_cycles, 3);
    check("pend_no_timeout", stall_timeout, 0);

    // Watchdog: 4 consecutive EX stalls trip the sticky timeout.
    do_reset();
    stallreq_for_ex = 1'b1;
    tick(); tick(); tick();
    check("wd_before", stall_timeout, 0);
    tick();
    check("wd_trip", stall_timeout, 1);
    check("wd_cycles", stall_cycles, 4);
    stallreq_for_ex = 1'b0;
    tick();
    tick();
    check("wd_sticky", stall_timeout, 1);
    check("wd_cycles_hold", stall_cycles, 4);

    // Counter saturation at all-ones for CNT_W=3.
    do_reset();
    stallreq_for_load = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("sat_10", stall_cycles, 7);
    tick();
    check("sat_11", stall_cycles, 7);
    stallreq_for_load = 1'b0;

    // Reset while in PEND discards the pending exception.
    do_reset();
    stallreq_for_mem = 1'b1;
    except_valid     = 1'b1;
    except_pc        = 32'hDEAD_0000;
    tick();
    except_valid = 1'b0;
    rst          = 1'b1;
    #1;
    check("rstp_stall", stall, 6'b000000);
    tick();
    check("rstp_flush", flush, 0);
    check("rstp_new_pc", new_pc, 0);
    check("rstp_timeout", stall_timeout, 0);
    check("rstp_cycles", stall_cycles, 0);
    rst              = 1'b0;
    stallreq_for_mem = 1'b0;
    tick();
    check("rstp_noflush1", flush, 0);
    tick();
    check("rstp_noflush2", flush, 0);
    check("rstp_pc_after", new_pc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_W, default 6, stall bus width; bit 0 = PC, bit i = pipeline stage i (1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
REQ-002 SHALL have parameter ID_IDX, default 2, stage index raising load-use stall.
REQ-003 SHALL have parameter EX_IDX, default 3, stage index raising multi-cycle EX stall.
REQ-004 SHALL have parameter MEM_IDX, default 4, stage index raising memory-wait stall; legal only if ID_IDX < EX_IDX < MEM_IDX < STALL_W.
REQ-005 SHALL have parameter MAX_STALL, default 64, consecutive-stall watchdog limit, >= 2.
REQ-006 SHALL have parameter CNT_W, default 32, stall performance counter width.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 stallreq_for_load  input  1  load-use hazard from ID.
REQ-010 stallreq_for_ex  input  1  multi-cycle op (mul/div) busy in EX.
REQ-011 stallreq_for_mem  input  1  data memory not ready in MEM.
REQ-012 except_valid  input  1  exception/redirect request, one-cycle pulse.
REQ-013 except_pc  input  32  redirect target, valid with except_valid.
REQ-014 stall  output  STALL_W  per-stage hold vector.
REQ-015 flush  output  1  pipeline flush, registered, one-cycle pulse.
REQ-016 new_pc  output  32  redirect target, registered, valid while flush=1.
REQ-017 stall_timeout  output  1  sticky watchdog error.
REQ-018 stall_cycles  output  CNT_W  saturating count of cycles with stall[0]=1.

Function
REQ-019 stall SHALL be combinational from requests and FSM state; lowest set stall bit is always 0, set bits form a contiguous run 0..k.
REQ-020 Priority SHALL be mem > ex > load: mem -> bits [MEM_IDX:0]=1; else ex -> bits [EX_IDX:0]=1; else load -> bits [ID_IDX:0]=1; else all 0. Bits above k SHALL be 0.
REQ-021 FSM states SHALL be RUN, PEND, FLUSH; reset state RUN.
REQ-022 RUN: except_valid=1 and stallreq_for_mem=0 at edge -> FLUSH, capture except_pc; except_valid=1 and stallreq_for_mem=1 -> PEND, capture except_pc; else stay RUN.
REQ-023 PEND: captured PC held; stall per REQ-020; at first edge with stallreq_for_mem=0 -> FLUSH; further except_valid pulses ignored (first exception wins).
REQ-024 FLUSH: lasts exactly one cycle; flush=1, new_pc=captured PC; stall SHALL be all 0 regardless of requests; except_valid ignored; next state RUN.
REQ-025 Latency: except_valid sampled at edge N (mem not stalling) -> flush=1 in cycle after edge N, i.e. one cycle.
REQ-026 flush=0 and new_pc holds last captured value outside FLUSH.
REQ-027 Watchdog: run counter increments each cycle stall!=0, clears to 0 on any cycle stall==0; when count reaches MAX_STALL, stall_timeout SHALL set and stay 1 until rst; counter saturates at MAX_STALL.
REQ-028 stall_cycles SHALL increment each cycle stall[0]=1 and saturate at all-ones (no wrap).
REQ-029 Simultaneous load+ex+mem requests SHALL yield mem encoding only; requests themselves are not latched.

Reset
REQ-030 While rst=1 stall SHALL be all 0 combinationally, regardless of requests.
REQ-031 At rst edge: state RUN, flush=0, new_pc=0, stall_timeout=0, stall_cycles=0, run counter=0.
REQ-032 rst during PEND or FLUSH SHALL discard pending exception; no flush issued after rst deasserts.

Verification
REQ-033 load=1 only, defaults -> stall=6'b000111; load+ex -> 6'b001111; load+ex+mem -> 6'b011111; all low -> 6'b000000.
REQ-034 except_valid=1, except_pc=0xBFC00380, mem=0 at edge N -> cycle N+1 flush=1, new_pc=0xBFC00380, stall=0 even with ex=1; cycle N+2 flush=0.
REQ-035 mem=1 held 3 cycles, except_valid at first, second pulse pc=0x1234 at second -> no flush while mem=1; flush=1 with first PC the cycle after mem drops; exactly one flush.
REQ-036 ex=1 held MAX_STALL=4 cycles -> stall_timeout=1 after 4th stalled cycle, stays 1 after ex drops; stall_cycles=4.
REQ-037 CNT_W=3, stall held 10 cycles -> stall_cycles=7 and holds.
REQ-038 rst asserted in PEND with mem=1 -> stall=0 during rst, no flush after release, all outputs at reset values.
